// File: rtl/pubkey_gen_iter.sv
// Iterative public key generator: Pk = (Sk + Q) mod P, computed by
// repeated subtraction of P, with ready/valid handshakes on both sides.
module pubkey_gen_iter #(
    parameter int W  = 8,
    parameter int P  = 227,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  secret_key,
    input  logic [W-1:0]  offset,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  public_key,
    output logic          err_invalid_seckey,
    output logic          busy,
    output logic [CW-1:0] key_count
);

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        OUT
    } state_t;

    localparam logic [W:0] P_EXT = (W+1)'(P);

    state_t        state, state_nxt;
    logic [W:0]    acc, acc_nxt;
    logic [W-1:0]  pk_nxt;
    logic          err_nxt;
    logic [CW-1:0] count_nxt;
    logic          sk_invalid;
    logic [W:0]    sum;

    // The accumulator is one bit wider so Sk+Q never loses its carry.
    assign sum        = {1'b0, secret_key} + {1'b0, offset};
    assign sk_invalid = (secret_key == '0) || ({1'b0, secret_key} >= P_EXT);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            acc                <= '0;
            public_key         <= '0;
            err_invalid_seckey <= 1'b0;
            key_count          <= '0;
        end else begin
            state              <= state_nxt;
            acc                <= acc_nxt;
            public_key         <= pk_nxt;
            err_invalid_seckey <= err_nxt;
            key_count          <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        pk_nxt    = public_key;
        err_nxt   = err_invalid_seckey;
        count_nxt = key_count;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (sk_invalid) begin
                        pk_nxt    = '0;
                        err_nxt   = 1'b1;
                        state_nxt = OUT;
                    end else begin
                        acc_nxt   = sum;
                        state_nxt = REDUCE;
                    end
                end
            end
            REDUCE: begin
                if (acc >= P_EXT) begin
                    acc_nxt = acc - P_EXT;
                end else begin
                    pk_nxt    = acc[W-1:0];
                    err_nxt   = 1'b0;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                // Only successfully generated keys are counted.
                if (out_ready) begin
                    state_nxt = IDLE;
                    if (!err_invalid_seckey) begin
                        count_nxt = key_count + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/pubkey_gen_iter.md
PUBKEY_GEN_ITER -- requirements
Module: pubkey_gen_iter

Interface
REQ-001 SHALL have parameter W, default 8: key/offset data width in bits, W >= 2.
REQ-002 SHALL have parameter P, default 227: modulus, 2 <= P <= 2^W-1.
REQ-003 SHALL have parameter CW, default 16: width of key_count.
REQ-004 SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: request present.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-008 SHALL have port secret_key, input, W bits: secret key Sk.
REQ-009 SHALL have port offset, input, W bits: run-time offset Q, any value 0..2^W-1.
REQ-010 SHALL have port out_valid, output, 1 bit: result present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-012 SHALL have port public_key, output, W bits: Pk = (Sk+Q) mod P.
REQ-013 SHALL have port err_invalid_seckey, output, 1 bit: result flags an invalid Sk.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port key_count, output, CW bits: number of valid keys delivered.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, REDUCE, OUT.
REQ-017 SHALL drive in_ready=1 only in IDLE; acceptance = in_valid && in_ready at a rising edge.
REQ-018 SHALL, on acceptance, capture Sk and Q: Sk invalid if Sk==0 or Sk>=P.
REQ-019 SHALL, for valid Sk on acceptance, load a W+1-bit accumulator with Sk+Q (no overflow loss) and go to REDUCE.
REQ-020 SHALL, for invalid Sk on acceptance, go directly to OUT with public_key=0 and err_invalid_seckey=1.
REQ-021 SHALL, in REDUCE, each cycle: if acc >= P, set acc = acc-P and stay; else load public_key = acc[W-1:0], err=0, go to OUT.
REQ-022 SHALL give latency n+1 cycles from the acceptance edge to out_valid for valid Sk, n = floor((Sk+Q)/P); latency is 1 cycle for invalid Sk.
REQ-023 SHALL hold out_valid=1 in OUT, with public_key and err_invalid_seckey stable until out_valid && out_ready at an edge.
REQ-024 SHALL, on the OUT handshake edge, return to IDLE and clear out_valid.
REQ-025 SHALL, on the same handshake edge, increment key_count by 1 only if err_invalid_seckey=0; key_count wraps from 2^CW-1 to 0.
REQ-026 SHALL keep public_key and err_invalid_seckey at their last delivered values outside OUT.
REQ-027 SHALL ignore secret_key and offset changes while not in IDLE.
REQ-028 SHALL allow at most one outstanding request; the next acceptance is no earlier than the cycle after the OUT handshake (IDLE cycle).

Reset
REQ-029 SHALL, on rst_n low, immediately and asynchronously set state=IDLE, in_ready=1, out_valid=0, busy=0, public_key=0, err_invalid_seckey=0, key_count=0, acc=0.
REQ-030 SHALL abandon any request in REDUCE or OUT on reset without delivering it or counting it.

Verification
REQ-031 SHALL cover: W=8,P=227, Sk=10,Q=5 accepted -> next cycle out_valid=1, public_key=15, err=0; out_ready=1 -> key_count=1.
REQ-032 SHALL cover: Sk=226,Q=200 (sum 426) -> out_valid 2 cycles after acceptance, public_key=199, err=0.
REQ-033 SHALL cover: Sk=0, then Sk=227, each with Q=9 -> out_valid 1 cycle after acceptance, public_key=0, err=1, key_count unchanged.
REQ-034 SHALL cover: Sk=100,Q=0 result held with out_ready=0 for 5 cycles -> public_key=100 stable, in_ready=0, busy=1, input changes ignored; out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover: P=3,W=8, Sk=2,Q=255 (sum 257) -> 85 REDUCE subtractions, out_valid 86 cycles after acceptance, public_key=2.
REQ-036 SHALL cover: rst_n pulsed low mid-REDUCE (P=3 case) -> all outputs at reset values at once, no out_valid, key_count=0; next request completes normally.
